// File: rtl/fun_pkg.sv
// Shared types and constants for the a^2 + cbrt(b) requester.
// Covers the operand/result widths, the requester FSM encoding and the watchdog counter sizing.
package fun_pkg;

  localparam int OP_W  = 8;
  localparam int RES_W = 16;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = S_IDLE,
    ISSUE = S_ISSUE,
    WAIT  = S_WAIT,
    RESP  = S_RESP
  } state_e;

  typedef struct packed {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
  } op_pair_t;

  localparam int PAIR_W = $bits(op_pair_t);

  // Watchdog counter must be able to hold TIMEOUT itself.
  function automatic int cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/fun_initiator_if.sv
// Request, compute-unit and response signals of the requester, grouped as one bundle.
// master = the requester itself, slave = the environment (producer, compute unit, consumer).
interface fun_initiator_if;
  import fun_pkg::*;

  logic             req_valid_i;
  logic             req_ready_o;
  logic [OP_W-1:0]  req_a_i;
  logic [OP_W-1:0]  req_b_i;

  logic             calc_start_o;
  logic [OP_W-1:0]  calc_a_o;
  logic [OP_W-1:0]  calc_b_o;
  logic             calc_busy_i;
  logic [RES_W-1:0] calc_result_i;

  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic [RES_W-1:0] rsp_result_o;
  logic             rsp_timeout_o;

  modport master (
    input  req_valid_i, req_a_i, req_b_i, calc_busy_i, calc_result_i, rsp_ready_i,
    output req_ready_o, calc_start_o, calc_a_o, calc_b_o, rsp_valid_o, rsp_result_o,
           rsp_timeout_o
  );

  modport slave (
    output req_valid_i, req_a_i, req_b_i, calc_busy_i, calc_result_i, rsp_ready_i,
    input  req_ready_o, calc_start_o, calc_a_o, calc_b_o, rsp_valid_o, rsp_result_o,
           rsp_timeout_o
  );

endinterface

// File: rtl/fun_initiator_op_fifo.sv
// Generic synchronous FIFO holding operand pairs; head is visible combinationally.
// Latency: written entry is readable the cycle after push. Backpressure: push ignored when full.
// Simultaneous push and pop keep the count unchanged.
module op_fifo
  import fun_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2 * OP_W
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           din_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CW'(1);
    end
  end

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/fun_initiator.sv
// Requester for the start/busy a^2 + cbrt(b) unit: queues operand pairs, issues one job at a time.
// Latency: queued pair to start pulse 1 cycle, busy-low to response 1 cycle, watchdog after TIMEOUT.
// Backpressure: req_ready_o drops when the queue is full; a held response stalls further issue.
module fun_initiator
  import fun_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input logic             clk_i,
  input logic             rst_i,
  fun_initiator_if.master bus
);

  localparam int CNT_W = cnt_width(TIMEOUT);
  localparam int FCW   = $clog2(DEPTH + 1);

  state_e             state_q;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic               calc_start_q;
  logic [OP_W-1:0]    calc_a_q, calc_b_q;
  logic               rsp_valid_q, rsp_timeout_q;
  logic [RES_W-1:0]   rsp_result_q;

  op_pair_t           push_dat, head_dat;
  logic               push, pop, fifo_full, fifo_empty, timed_out;
  logic [FCW-1:0]     fifo_count;

  assign push_dat   = {bus.req_a_i, bus.req_b_i};
  assign push       = bus.req_valid_i && !fifo_full;
  // Never start into a busy unit: after a watchdog expiry the unit may still be grinding.
  assign pop        = (state_q == IDLE) && !fifo_empty && !bus.calc_busy_i && !rsp_valid_q;
  assign wait_cnt_d = wait_cnt_q + CNT_W'(1);
  assign timed_out  = (wait_cnt_q == CNT_W'(TIMEOUT - 1));

  op_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PAIR_W)
  ) u_op_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (push_dat),
    .dout_o  (head_dat),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      wait_cnt_q    <= '0;
      calc_start_q  <= 1'b0;
      calc_a_q      <= '0;
      calc_b_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            calc_a_q     <= head_dat.a;
            calc_b_q     <= head_dat.b;
            calc_start_q <= 1'b1;
            state_q      <= ISSUE;
          end
        end
        ISSUE: begin
          calc_start_q <= 1'b0;
          wait_cnt_q   <= '0;
          state_q      <= WAIT;
        end
        WAIT: begin
          if (!bus.calc_busy_i) begin
            rsp_result_q  <= bus.calc_result_i;
            rsp_timeout_q <= 1'b0;
            rsp_valid_q   <= 1'b1;
            state_q       <= RESP;
          end else if (timed_out) begin
            rsp_result_q  <= '0;
            rsp_timeout_q <= 1'b1;
            rsp_valid_q   <= 1'b1;
            state_q       <= RESP;
          end else begin
            wait_cnt_q <= wait_cnt_d;
          end
        end
        RESP: begin
          if (bus.rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready_o   = (fifo_count < FCW'(DEPTH));
  assign bus.calc_start_o  = calc_start_q;
  assign bus.calc_a_o      = calc_a_q;
  assign bus.calc_b_o      = calc_b_q;
  assign bus.rsp_valid_o   = rsp_valid_q;
  assign bus.rsp_result_o  = rsp_result_q;
  assign bus.rsp_timeout_o = rsp_timeout_q;

  a_start_single: assert property (@(posedge clk_i) disable iff (rst_i)
    calc_start_q |=> !calc_start_q);

  a_rsp_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (rsp_valid_q && !bus.rsp_ready_i) |=>
      (rsp_valid_q && $stable(rsp_result_q) && $stable(rsp_timeout_q)));

endmodule

// File: tb/tb_fun_initiator.sv
// Bench for fun_initiator: table of directed jobs, corner sequences and a randomized scoreboard run.
module tb_fun_initiator;
  import fun_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;
  localparam int LAT     = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fun_initiator_if bus();

  fun_initiator #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int vecs = 0;
  int errs = 0;

  task automatic check(input string name, input longint act, input longint exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  function automatic int ref_res(input int a, input int b);
    int r = 0;
    while ((r + 1) * (r + 1) * (r + 1) <= b) r++;
    return a * a + r;
  endfunction

  // Behavioural compute unit: busy for LAT cycles after a start, or forever while hang is set.
  logic        hang = 1'b0;
  logic        m_busy;
  int          m_left;
  logic [15:0] m_res;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_left <= 0;
      m_res  <= 16'h0;
    end else if (bus.calc_start_o) begin
      m_busy <= 1'b1;
      m_left <= LAT - 1;
      m_res  <= 16'(ref_res(int'(bus.calc_a_o), int'(bus.calc_b_o)));
    end else if (m_busy && !hang) begin
      if (m_left == 0) m_busy <= 1'b0;
      else             m_left <= m_left - 1;
    end
  end

  assign bus.calc_busy_i   = m_busy;
  assign bus.calc_result_i = m_busy ? 16'hDEAD : m_res;

  // Scoreboard: pairs in acceptance order, checked at issue and at response.
  logic        sb_en = 1'b0;
  logic [15:0] pair_q[$];
  int          exp_q[$];
  int          start_cnt = 0;
  int          rsp_cnt   = 0;
  logic        prev_start = 1'b0;
  logic [15:0] p;
  int          e;

  always @(negedge clk) begin
    if (rst) begin
      prev_start = 1'b0;
    end else begin
      if (bus.calc_start_o) begin
        start_cnt++;
        check("start_twice", prev_start, 0);
        check("start_busy", bus.calc_busy_i, 0);
        if (sb_en) begin
          if (pair_q.size() == 0) begin
            check("issue_unexpected", 1, 0);
          end else begin
            p = pair_q.pop_front();
            check("issue_a", bus.calc_a_o, p[15:8]);
            check("issue_b", bus.calc_b_o, p[7:0]);
          end
        end
      end
      prev_start = bus.calc_start_o;
      if (bus.rsp_valid_o && bus.rsp_ready_i) begin
        rsp_cnt++;
        if (sb_en) begin
          if (exp_q.size() == 0) begin
            check("rsp_unexpected", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("rsp_result", bus.rsp_result_o, e);
            check("rsp_timeout", bus.rsp_timeout_o, 0);
          end
        end
      end
      if (sb_en && bus.req_valid_i && bus.req_ready_o) begin
        pair_q.push_back({bus.req_a_i, bus.req_b_i});
        exp_q.push_back(ref_res(int'(bus.req_a_i), int'(bus.req_b_i)));
      end
    end
  end

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] r;
  } vec_t;

  vec_t tbl[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pair(input logic [7:0] a, input logic [7:0] b);
    bus.req_valid_i = 1'b1;
    bus.req_a_i     = a;
    bus.req_b_i     = b;
    tick();
    bus.req_valid_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, t, acc, sc, rc;
    tbl[0] = '{8'd3,   8'd27,  16'd12};
    tbl[1] = '{8'd255, 8'd255, 16'd65031};
    tbl[2] = '{8'd0,   8'd0,   16'd0};
    tbl[3] = '{8'd16,  8'd64,  16'd260};
    tbl[4] = '{8'd2,   8'd8,   16'd6};
    tbl[5] = '{8'd7,   8'd26,  16'd51};
    tbl[6] = '{8'd100, 8'd200, 16'd10005};
    tbl[7] = '{8'd1,   8'd1,   16'd2};

    bus.req_valid_i = 1'b0;
    bus.req_a_i     = '0;
    bus.req_b_i     = '0;
    bus.rsp_ready_i = 1'b0;

    repeat (3) tick();
    check("rst_start", bus.calc_start_o, 0);
    check("rst_a", bus.calc_a_o, 0);
    check("rst_b", bus.calc_b_o, 0);
    check("rst_rsp_valid", bus.rsp_valid_o, 0);
    check("rst_result", bus.rsp_result_o, 0);
    check("rst_timeout", bus.rsp_timeout_o, 0);
    rst = 1'b0;
    tick();
    check("rst_ready", bus.req_ready_o, 1);
    bus.rsp_ready_i = 1'b1;

    // Directed jobs: start one cycle after push, response LAT+2 cycles after start.
    for (int i = 0; i < 8; i++) begin
      push_pair(tbl[i].a, tbl[i].b);
      n = 0;
      while (!bus.calc_start_o && n < 20) begin tick(); n++; end
      check("start_lat", n, 1);
      check("calc_a", bus.calc_a_o, tbl[i].a);
      check("calc_b", bus.calc_b_o, tbl[i].b);
      n = 0;
      while (!bus.rsp_valid_o && n < 40) begin tick(); n++; end
      check("rsp_lat", n, LAT + 2);
      check("vec_result", bus.rsp_result_o, tbl[i].r);
      check("vec_timeout", bus.rsp_timeout_o, 0);
      tick();
      check("rsp_clear", bus.rsp_valid_o, 0);
    end

    // Full queue with a blocked response, then backpressure hold, then drain in order.
    sb_en = 1'b1;
    rc = rsp_cnt;
    bus.rsp_ready_i = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      bus.req_valid_i = 1'b1;
      bus.req_a_i     = 8'(10 + i);
      bus.req_b_i     = 8'(i * 50);
      if (bus.req_ready_o) acc++;
      tick();
    end
    bus.req_valid_i = 1'b0;
    check("fifo_accepted", acc, DEPTH + 1);
    check("full_ready", bus.req_ready_o, 0);
    n = 0;
    while (!bus.rsp_valid_o && n < 40) begin tick(); n++; end
    check("bp_rsp_seen", bus.rsp_valid_o, 1);
    sc = start_cnt;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_valid", bus.rsp_valid_o, 1);
      check("bp_result", bus.rsp_result_o, 100);
    end
    check("bp_no_start", start_cnt, sc);
    check("bp_ready_low", bus.req_ready_o, 0);
    bus.rsp_ready_i = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin tick(); n++; end
    check("full_drain", exp_q.size(), 0);
    check("full_rsp_count", rsp_cnt - rc, DEPTH + 1);

    // Randomized traffic with random response backpressure.
    for (int i = 0; i < 500; i++) begin
      bus.req_valid_i = ($urandom_range(0, 3) != 0);
      bus.req_a_i     = 8'($urandom);
      bus.req_b_i     = 8'($urandom);
      bus.rsp_ready_i = ($urandom_range(0, 3) != 0);
      tick();
    end
    bus.req_valid_i = 1'b0;
    bus.rsp_ready_i = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || pair_q.size() != 0) && n < 2000) begin tick(); n++; end
    check("rand_drain_rsp", exp_q.size(), 0);
    check("rand_drain_issue", pair_q.size(), 0);
    tick();
    sb_en = 1'b0;

    // Watchdog: the unit hangs; the queued job must wait for busy to fall.
    hang = 1'b1;
    bus.rsp_ready_i = 1'b0;
    bus.req_valid_i = 1'b1;
    bus.req_a_i = 8'd1;
    bus.req_b_i = 8'd1;
    tick();
    bus.req_a_i = 8'd2;
    bus.req_b_i = 8'd8;
    tick();
    bus.req_valid_i = 1'b0;
    n = 0;
    while (!bus.calc_start_o && n < 20) begin tick(); n++; end
    check("to_start_seen", bus.calc_start_o, 1);
    t = 0;
    while (!bus.rsp_valid_o && t < 100) begin tick(); t++; end
    check("to_lat_window", (t >= TIMEOUT && t <= TIMEOUT + 3) ? 1 : 0, 1);
    check("to_flag", bus.rsp_timeout_o, 1);
    check("to_result", bus.rsp_result_o, 0);
    bus.rsp_ready_i = 1'b1;
    tick();
    bus.rsp_ready_i = 1'b0;
    check("to_rsp_clear", bus.rsp_valid_o, 0);
    sc = start_cnt;
    repeat (20) tick();
    check("to_blocked", start_cnt, sc);
    hang = 1'b0;
    n = 0;
    while (!bus.calc_start_o && n < 30) begin tick(); n++; end
    check("to_next_start", bus.calc_start_o, 1);
    check("to_next_a", bus.calc_a_o, 2);
    check("to_next_b", bus.calc_b_o, 8);
    n = 0;
    while (!bus.rsp_valid_o && n < 40) begin tick(); n++; end
    check("to_next_result", bus.rsp_result_o, 6);
    check("to_next_flag", bus.rsp_timeout_o, 0);
    bus.rsp_ready_i = 1'b1;
    tick();

    // Asynchronous reset while waiting on the unit, with a second pair still queued.
    bus.req_valid_i = 1'b1;
    bus.req_a_i = 8'd9;
    bus.req_b_i = 8'd9;
    tick();
    bus.req_a_i = 8'd5;
    bus.req_b_i = 8'd5;
    tick();
    bus.req_valid_i = 1'b0;
    repeat (3) tick();
    check("pre_rst_a", bus.calc_a_o, 9);
    check("pre_rst_result", bus.rsp_result_o, 6);
    #3 rst = 1'b1;
    #1;
    check("arst_start", bus.calc_start_o, 0);
    check("arst_a", bus.calc_a_o, 0);
    check("arst_b", bus.calc_b_o, 0);
    check("arst_valid", bus.rsp_valid_o, 0);
    check("arst_result", bus.rsp_result_o, 0);
    check("arst_timeout", bus.rsp_timeout_o, 0);
    check("arst_ready", bus.req_ready_o, 1);
    #3 rst = 1'b0;
    sc = start_cnt;
    rc = rsp_cnt;
    repeat (30) tick();
    check("post_rst_no_start", start_cnt, sc);
    check("post_rst_no_rsp", rsp_cnt, rc);
    check("post_rst_ready", bus.req_ready_o, 1);
    push_pair(8'd3, 8'd27);
    n = 0;
    while (!bus.rsp_valid_o && n < 40) begin tick(); n++; end
    check("post_rst_result", bus.rsp_result_o, 12);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/fun_initiator.md
Name: fun_initiator

Overview:
- Requester-side master for the start/busy compute handshake used by the a² + cbrt(b) unit.
- Accepts operand pairs on a valid/ready request port and buffers them in a small FIFO.
- Issues operands one at a time to the compute unit. Waits for completion and returns each 16-bit result on a valid/ready response port.
- Watchdog timeout keeps a hung unit from blocking the requester.

Parameters:
- DEPTH, 4, operand FIFO entries; power of two, ≥2.
- TIMEOUT, 255, max cycles waiting for calc_busy_i to fall after issue; ≥2.

Ports:
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- req_valid_i  in  1  operand pair offered
- req_ready_o  out  1  FIFO can accept; high iff count < DEPTH
- req_a_i  in  8  operand a
- req_b_i  in  8  operand b
- calc_start_o  out  1  one-cycle start pulse to compute unit
- calc_a_o  out  8  operand a to compute unit
- calc_b_o  out  8  operand b to compute unit
- calc_busy_i  in  1  compute unit busy
- calc_result_i  in  16  compute unit result; valid when busy low after a job
- rsp_valid_o  out  1  response held
- rsp_ready_i  in  1  consumer accepts response
- rsp_result_o  out  16  returned result
- rsp_timeout_o  out  1  response is a timeout, not a result

Behaviour:
- Reset (async) values:
  - FSM = IDLE; FIFO empty; wait counter = 0.
  - calc_start_o = 0; calc_a_o = 0; calc_b_o = 0.
  - rsp_valid_o = 0; rsp_result_o = 0; rsp_timeout_o = 0.
  - req_ready_o = 1 once reset is deasserted.
- Reset mid-operation: discards queued operands and any pending response. Any job in flight in the compute unit is abandoned.
- Request push:
  - Occurs on a cycle with req_valid_i && req_ready_o.
  - Writes {a,b} at the write pointer; pointer wraps modulo DEPTH.
  - Push and pop in the same cycle are allowed; count is unchanged.
  - When full, req_ready_o = 0 and the offered pair is not stored.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE → ISSUE when FIFO non-empty && !calc_busy_i && !rsp_valid_o. On that edge:
    - pop the head into the calc_a_o/calc_b_o registers;
    - set calc_start_o = 1.
  - ISSUE lasts exactly 1 cycle with calc_start_o = 1. Next edge: calc_start_o = 0, wait counter = 0, go to WAIT.
  - WAIT:
    - Operands stay stable.
    - When calc_busy_i == 0: capture calc_result_i into rsp_result_o, set rsp_timeout_o = 0 and rsp_valid_o = 1, go to RESP.
    - Otherwise increment the counter. When the counter reaches TIMEOUT-1 with busy still high: set rsp_result_o = 16'h0000, rsp_timeout_o = 1, rsp_valid_o = 1, go to RESP.
  - RESP → IDLE on rsp_valid_o && rsp_ready_i. rsp_valid_o clears on that edge; the result register holds its value.
- Response outputs stay stable while rsp_valid_o && !rsp_ready_i.
- Latency:
  - Non-empty FIFO to start pulse: 1 cycle.
  - Completion detect to rsp_valid_o: 1 cycle.
  - Minimum turnaround per job: compute latency + 4 cycles.
- After a timeout, the next issue is blocked until calc_busy_i is low, so start is never asserted into a busy unit.
- calc_start_o is never high for 2 consecutive cycles.
- Ordering: responses return strictly in request order.

Decomposition:
- Package fun_pkg:
  - OP_W = 8, RES_W = 16;
  - state encoding localparams IDLE/ISSUE/WAIT/RESP;
  - counter width computed as $clog2(TIMEOUT+1).
- One sub-module, op_fifo: synchronous FIFO with parameters DEPTH and width 16. Ports push, pop, din, dout, full, empty, count; async reset.
- Top holds the FSM, wait counter and response register.

Test Plan:
- Basic job: behavioural compute model (a² + integer cbrt(b), busy 5 cycles). Push a=3,b=27 → one start pulse with calc_a_o=3, calc_b_o=27. Then rsp_valid_o=1, rsp_result_o=12, rsp_timeout_o=0.
- Max operands: a=255,b=255 → rsp_result_o=65031. Then a=0,b=0 → 0; a=16,b=64 → 260. All returned in order.
- FIFO full: rsp_ready_i=0 throughout; push 6 pairs back-to-back. First pair issues and its response blocks. After DEPTH more pairs are stored, req_ready_o=0 and no more pushes are accepted. Raise rsp_ready_i → all 5 stored pairs complete in order.
- Backpressure: hold rsp_ready_i=0 for 10 cycles after a response. rsp_result_o stays stable, no new start pulse, next pops only after the handshake.
- Timeout: TIMEOUT=8, model holds busy high forever. Response arrives with rsp_timeout_o=1, rsp_result_o=0. The next queued job does not start until the model drops busy.
- Reset mid-WAIT: assert rst_i asynchronously between edges. All outputs return to reset values immediately. After release, the FIFO is empty and no response is emitted for the abandoned job.
